// File: rtl/hex_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_entry_pkg
// Description : Shared FSM state encoding and constants for the hex entry block.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_entry_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [2:0]  DIGITS_FULL      = 3'd4;
    localparam logic [19:0] DEBOUNCE_DEFAULT = 20'd500000;

endpackage
`default_nettype wire

// File: rtl/hex_entry_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : 2-flop synchronizer, debounce counter and press (fall) pulse
//               for one raw active-low pushbutton.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import hex_entry_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic press
);

    logic [1:0]  sync_q, sync_d;
    logic        deb_q, deb_d;
    logic [19:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], key_n};
        deb_d  = deb_q;
        cnt_d  = 20'd0;
        press  = 1'b0;
        // Count only while the synchronized level disagrees; any agreement restarts.
        if (sync_q[1] != deb_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
                deb_d = sync_q[1];
                press = deb_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b11;
            deb_q  <= 1'b1;
            cnt_q  <= 20'd0;
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hex_entry.sv
`default_nettype none
// ============================================================================
// Module      : hex_entry
// Description : Four-digit hex entry register driven by debounced enter/clear
//               pushbuttons, with a valid/ack handshake for completed values.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        key_enter_n,
    input  logic        key_clear_n,
    input  logic [3:0]  sw_digit,
    input  logic        value_ack,
    output logic [15:0] value,
    output logic        value_valid,
    output logic [2:0]  digit_count
);

    logic enter_evt;
    logic clear_evt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_deb (
        .clock  (clock),
        .resetn (resetn),
        .key_n  (key_enter_n),
        .press  (enter_evt)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_deb (
        .clock  (clock),
        .resetn (resetn),
        .key_n  (key_clear_n),
        .press  (clear_evt)
    );

    state_e      state_q, state_d;
    logic [15:0] value_q, value_d;
    logic [2:0]  count_q, count_d;
    logic        valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        count_d = count_q;
        valid_d = valid_q;
        // Priority: clear, then acknowledge, then enter.
        if (clear_evt || (value_ack && state_q == ST_FULL)) begin
            state_d = ST_EMPTY;
            value_d = 16'h0000;
            count_d = 3'd0;
            valid_d = 1'b0;
        end else if (enter_evt && state_q != ST_FULL) begin
            value_d = {value_q[11:0], sw_digit};
            count_d = count_q + 3'd1;
            if (count_d == DIGITS_FULL) begin
                state_d = ST_FULL;
                valid_d = 1'b1;
            end else begin
                state_d = ST_ENTRY;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            value_q <= 16'h0000;
            count_q <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign digit_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_entry
// Description : Self-checking bench for hex_entry with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_entry;

    localparam int N = 4;

    logic        clock;
    logic        resetn;
    logic        key_enter_n;
    logic        key_clear_n;
    logic [3:0]  sw_digit;
    logic        value_ack;
    logic [15:0] value;
    logic        value_valid;
    logic [2:0]  digit_count;

    int errors = 0;
    int checks = 0;

    hex_entry #(.DEBOUNCE_CYCLES(20'd4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .key_enter_n (key_enter_n),
        .key_clear_n (key_clear_n),
        .sw_digit    (sw_digit),
        .value_ack   (value_ack),
        .value       (value),
        .value_valid (value_valid),
        .digit_count (digit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: per key, the last N synchronized samples and the accepted level.
    bit          m_s1   [2];
    bit          m_deb  [2];
    bit          m_hist [2][N];
    logic [15:0] m_value;
    logic [2:0]  m_count;
    logic        m_valid;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k]  = 1'b1;
            m_deb[k] = 1'b1;
            for (int i = 0; i < N; i++) m_hist[k][i] = 1'b1;
        end
        m_value = 16'h0000;
        m_count = 3'd0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_edge();
        bit raw [2];
        bit ev  [2];
        bit all_diff;
        raw[0] = key_enter_n;
        raw[1] = key_clear_n;
        for (int k = 0; k < 2; k++) begin
            ev[k] = 1'b0;
            all_diff = 1'b1;
            for (int i = 0; i < N; i++)
                if (m_hist[k][i] == m_deb[k]) all_diff = 1'b0;
            if (all_diff) begin
                m_deb[k] = ~m_deb[k];
                ev[k]    = (m_deb[k] == 1'b0);
            end
            for (int i = 0; i < N - 1; i++) m_hist[k][i] = m_hist[k][i+1];
            m_hist[k][N-1] = m_s1[k];
            m_s1[k]        = raw[k];
        end
        if (ev[1] || (value_ack && m_count == 3'd4)) begin
            m_value = 16'h0000;
            m_count = 3'd0;
            m_valid = 1'b0;
        end else if (ev[0] && m_count < 3'd4) begin
            m_value = {m_value[11:0], sw_digit};
            m_count = m_count + 3'd1;
            m_valid = (m_count == 3'd4);
        end
    endfunction

    task automatic check_model(input string tag);
        checks++;
        assert (value === m_value) else begin
            errors++;
            $error("FAIL %s value obs=%h exp=%h", tag, value, m_value);
        end
        checks++;
        assert (digit_count === m_count) else begin
            errors++;
            $error("FAIL %s digit_count obs=%0d exp=%0d", tag, digit_count, m_count);
        end
        checks++;
        assert (value_valid === m_valid) else begin
            errors++;
            $error("FAIL %s value_valid obs=%b exp=%b", tag, value_valid, m_valid);
        end
    endtask

    task automatic check_const(input string tag, input logic [15:0] v, input logic [2:0] c,
                               input logic vld);
        checks++;
        assert (value === v) else begin
            errors++;
            $error("FAIL %s value obs=%h exp=%h", tag, value, v);
        end
        checks++;
        assert (digit_count === c) else begin
            errors++;
            $error("FAIL %s digit_count obs=%0d exp=%0d", tag, digit_count, c);
        end
        checks++;
        assert (value_valid === vld) else begin
            errors++;
            $error("FAIL %s value_valid obs=%b exp=%b", tag, value_valid, vld);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        if (resetn) model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic press_enter(input logic [3:0] d);
        sw_digit    = d;
        key_enter_n = 1'b0;
        ticks(8, "press");
        key_enter_n = 1'b1;
        ticks(8, "release");
    endtask

    initial begin
        resetn      = 1'b0;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        sw_digit    = 4'h0;
        value_ack   = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        check_const("reset_state", 16'h0000, 3'd0, 1'b0);

        // Clean entry of 1,2,3,4 with partial values visible.
        press_enter(4'h1);
        check_const("digit1", 16'h0001, 3'd1, 1'b0);
        press_enter(4'h2);
        check_const("digit2", 16'h0012, 3'd2, 1'b0);
        press_enter(4'h3);
        check_const("digit3", 16'h0123, 3'd3, 1'b0);
        press_enter(4'h4);
        check_const("digit4", 16'h1234, 3'd4, 1'b1);

        // Enter ignored in FULL, then ack empties.
        press_enter(4'hF);
        check_const("full_ignore", 16'h1234, 3'd4, 1'b1);
        value_ack = 1'b1;
        tick("ack");
        value_ack = 1'b0;
        check_const("ack_clears", 16'h0000, 3'd0, 1'b0);
        ticks(2, "post_ack");

        // Bounce: 3 low, 1 high, 10 low -> one event only.
        sw_digit    = 4'h7;
        key_enter_n = 1'b0;
        ticks(3, "glitch_low");
        key_enter_n = 1'b1;
        ticks(1, "glitch_high");
        key_enter_n = 1'b0;
        ticks(10, "bounce_low");
        key_enter_n = 1'b1;
        ticks(8, "bounce_rel");
        check_const("bounce_one_event", 16'h0007, 3'd1, 1'b0);

        // Clear and enter pressed together: clear wins.
        key_clear_n = 1'b0;
        ticks(8, "clr");
        key_clear_n = 1'b1;
        ticks(8, "clr_rel");
        press_enter(4'hA);
        press_enter(4'hB);
        check_const("ab", 16'h00AB, 3'd2, 1'b0);
        sw_digit    = 4'hC;
        key_enter_n = 1'b0;
        key_clear_n = 1'b0;
        ticks(8, "simul");
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        ticks(8, "simul_rel");
        check_const("clear_wins", 16'h0000, 3'd0, 1'b0);

        // Reset mid-entry with enter held across deassertion.
        press_enter(4'h5);
        press_enter(4'h6);
        press_enter(4'h8);
        sw_digit    = 4'h9;
        key_enter_n = 1'b0;
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_const("async_reset", 16'h0000, 3'd0, 1'b0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        ticks(5, "held_wait");
        check_const("held_no_event_yet", 16'h0000, 3'd0, 1'b0);
        tick("held_event");
        check_const("held_event", 16'h0009, 3'd1, 1'b0);
        key_enter_n = 1'b1;
        ticks(8, "held_rel");

        // Random key activity checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0)  key_enter_n = ~key_enter_n;
            if ($urandom_range(0, 29) == 0) key_clear_n = ~key_clear_n;
            value_ack = ($urandom_range(0, 9) == 0);
            sw_digit  = 4'($urandom_range(0, 15));
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
